fir_mac_sequencer: RTL and testbench

//  Sequences one time-shared MAC datapath through all NUM_TAPS taps of the audio FIR filter per input sample.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_ring_ptr.sv | 21 ++
 rtl/fir_mac_sequencer.sv | 96 +++++++++
 tb/tb_fir_mac_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and default sizes for the FIR MAC sequencer.
package fir_pkg;
  localparam int NUM_TAPS_DEF = 64;
  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF = 40;
  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_OUT
  } fir_seq_state_e;
endpackage

// File: rtl/fir_ring_ptr.sv
// fir_ring_ptr: ADDR_W modular counter with clear, increment and wrapped offset-subtract output.
module fir_ring_ptr #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] off_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic [ADDR_W-1:0] sub_o
);
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = clr_i ? '0 : inc_i ? ptr_q + ADDR_W'(1) : ptr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
  assign ptr_o = ptr_q;
  assign sub_o = ptr_q - off_i;
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: walks one shared MAC through all taps per sample over a circular delay line.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int ADDR_W = $clog2(NUM_TAPS),
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  input  logic              flush_i,
  output logic              dl_we_o,
  output logic [ADDR_W-1:0] dl_waddr_o,
  output logic [DATA_W-1:0] dl_wdata_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] dl_raddr_o,
  output logic [ADDR_W-1:0] coeff_raddr_o,
  output logic              mac_clear_o,
  output logic              mac_en_o,
  output logic              mac_last_o,
  input  logic [ACC_W-1:0]  acc_i,
  output logic [ACC_W-1:0]  result_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              busy_o
);
  fir_seq_state_e state_q, state_d;
  logic [ADDR_W-1:0] head, k, k_sub, rd_addr;
  logic [2:0] strb_q, strb_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic k_last, accept;
  assign k_last = k == ADDR_W'(NUM_TAPS - 1);
  assign accept = state_q == S_IDLE && !flush_i && sample_valid_i;
  // head - k gives the delay-line slot of tap k; k = 0 is the newest sample
  fir_ring_ptr #(.ADDR_W(ADDR_W)) u_head (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(state_q == S_CLEAR && k_last),
    .inc_i(state_q == S_CAPTURE),
    .off_i(k),
    .ptr_o(head),
    .sub_o(rd_addr)
  );
  fir_ring_ptr #(.ADDR_W(ADDR_W)) u_tap (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(state_q == S_IDLE),
    .inc_i(state_q == S_CLEAR || state_q == S_RUN),
    .off_i('0),
    .ptr_o(k),
    .sub_o(k_sub)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:   state_d = k_last ? S_IDLE : S_CLEAR;
      S_IDLE:    state_d = flush_i ? S_CLEAR : sample_valid_i ? S_RUN : S_IDLE;
      S_RUN:     state_d = k_last ? S_DRAIN : S_RUN;
      S_DRAIN:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUT;
      S_OUT:     state_d = result_ready_i ? S_IDLE : S_OUT;
      default:   state_d = S_CLEAR;
    endcase
  end
  assign sample_ready_o = state_q == S_IDLE && !flush_i;
  assign dl_we_o = state_q == S_CLEAR || accept;
  assign dl_waddr_o = state_q == S_CLEAR ? k : head;
  assign dl_wdata_o = accept ? sample_i : '0;
  assign rd_en_o = state_q == S_RUN;
  assign dl_raddr_o = rd_en_o ? rd_addr : '0;
  assign coeff_raddr_o = rd_en_o ? k_sub : '0;
  // MAC strobes trail the RAM reads by the one-cycle read latency
  assign strb_d = {rd_en_o, rd_en_o && k == '0, rd_en_o && k_last};
  assign mac_en_o = strb_q[2];
  assign mac_clear_o = strb_q[1];
  assign mac_last_o = strb_q[0];
  assign result_d = state_q == S_CAPTURE ? acc_i : result_q;
  assign result_o = result_q;
  assign result_valid_o = state_q == S_OUT;
  assign busy_o = state_q != S_IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      strb_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      strb_q <= strb_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: random samples/coefficients against a direct-form FIR sum over the sample history.
module tb_fir_mac_sequencer;
  logic clk = 0, rst = 1;
  logic [15:0] sample_i = '0;
  logic sample_valid_i = 0, flush_i = 0, result_ready_i = 0;
  logic sample_ready_o, dl_we_o, rd_en_o, mac_clear_o, mac_en_o, mac_last_o, result_valid_o, busy_o;
  logic [5:0] dl_waddr_o, dl_raddr_o, coeff_raddr_o;
  logic [15:0] dl_wdata_o;
  logic [39:0] acc_i, result_o;
  int checks = 0, errors = 0, exp_head = 0;
  logic signed [15:0] mem [64];
  logic signed [15:0] coef [64];
  logic signed [15:0] hist [$];
  logic signed [15:0] dl_rd, cf_rd;
  logic signed [31:0] prod;
  logic signed [39:0] acc;
  always #5 clk = ~clk;
  fir_mac_sequencer dut (
    .clk_i(clk), .rst_i(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o), .flush_i(flush_i), .dl_we_o(dl_we_o), .dl_waddr_o(dl_waddr_o),
    .dl_wdata_o(dl_wdata_o), .rd_en_o(rd_en_o), .dl_raddr_o(dl_raddr_o), .coeff_raddr_o(coeff_raddr_o),
    .mac_clear_o(mac_clear_o), .mac_en_o(mac_en_o), .mac_last_o(mac_last_o), .acc_i(acc_i),
    .result_o(result_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .busy_o(busy_o)
  );
  // Environment: delay-line and coefficient RAMs with 1-cycle read latency, plus the MAC unit
  assign prod = dl_rd * cf_rd;
  assign acc_i = acc;
  always @(posedge clk) begin
    if (dl_we_o) mem[dl_waddr_o] <= dl_wdata_o;
    if (rd_en_o) begin
      dl_rd <= mem[dl_raddr_o];
      cf_rd <= coef[coeff_raddr_o];
    end
    if (mac_en_o) acc <= (mac_clear_o ? 40'sd0 : acc) + 40'(prod);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [39:0] ref_out();
    longint s = 0;
    for (int t = 0; t < hist.size(); t++) s += longint'(coef[t]) * longint'(hist[t]);
    return s[39:0];
  endfunction
  task automatic wait_clear();
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("clr_we", dl_we_o, 1);
      chk("clr_waddr", dl_waddr_o, i);
      chk("clr_wdata", dl_wdata_o, 0);
      chk("clr_sready", sample_ready_o, 0);
      chk("clr_busy", busy_o, 1);
      @(negedge clk);
    end
    #1;
    chk("idle_sready", sample_ready_o, 1);
    chk("idle_busy", busy_o, 0);
  endtask
  task automatic do_sample(input logic [15:0] x, input int bp);
    logic [39:0] r_exp;
    sample_i = x;
    sample_valid_i = 1;
    #1;
    chk("acc_ready", sample_ready_o, 1);
    chk("acc_we", dl_we_o, 1);
    chk("acc_waddr", dl_waddr_o, exp_head);
    chk("acc_wdata", dl_wdata_o, x);
    hist.push_front(x);
    if (hist.size() > 64) void'(hist.pop_back());
    r_exp = ref_out();
    @(negedge clk);
    sample_valid_i = 0;
    for (int c = 1; c <= 66; c++) begin
      result_ready_i = 1'($urandom_range(0, 1));
      #1;
      chk("rd_en", rd_en_o, c <= 64);
      if (c <= 64) begin
        chk("dl_raddr", dl_raddr_o, (exp_head - (c - 1)) & 63);
        chk("coeff_raddr", coeff_raddr_o, c - 1);
      end
      chk("mac_en", mac_en_o, c >= 2 && c <= 65);
      chk("mac_clear", mac_clear_o, c == 2);
      chk("mac_last", mac_last_o, c == 65);
      chk("run_rvalid", result_valid_o, 0);
      chk("run_sready", sample_ready_o, 0);
      @(negedge clk);
    end
    result_ready_i = 0;
    #1;
    chk("rvalid", result_valid_o, 1);
    chk("result", result_o, r_exp);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      sample_valid_i = 1;
      sample_i = 16'($urandom);
      #1;
      chk("bp_rvalid", result_valid_o, 1);
      chk("bp_result", result_o, r_exp);
      chk("bp_sready", sample_ready_o, 0);
      chk("bp_we", dl_we_o, 0);
    end
    @(negedge clk);
    sample_valid_i = 0;
    result_ready_i = 1;
    #1;
    chk("hs_rvalid", result_valid_o, 1);
    chk("hs_result", result_o, r_exp);
    @(negedge clk);
    result_ready_i = 0;
    #1;
    chk("back_idle", busy_o, 0);
    exp_head = (exp_head + 1) % 64;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) coef[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy_o, 1);
    chk("rst_rvalid", result_valid_o, 0);
    chk("rst_mac_en", mac_en_o, 0);
    chk("rst_sready", sample_ready_o, 0);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_result", result_o, 0);
    rst = 0;
    wait_clear();
    do_sample(16'h7FFF, 0);
    for (int i = 0; i < 64; i++) do_sample(16'($urandom), i == 30 ? 10 : 0);
    flush_i = 1;
    sample_valid_i = 1;
    sample_i = 16'h1234;
    #1;
    chk("fl_sready", sample_ready_o, 0);
    chk("fl_we", dl_we_o, 0);
    @(negedge clk);
    flush_i = 0;
    sample_valid_i = 0;
    wait_clear();
    hist.delete();
    exp_head = 0;
    do_sample(16'($urandom), 0);
    do_sample(16'($urandom), 0);
    sample_i = 16'($urandom);
    sample_valid_i = 1;
    @(negedge clk);
    sample_valid_i = 0;
    repeat (20) @(negedge clk);
    #1;
    chk("mid_k20", coeff_raddr_o, 20);
    rst = 1;
    @(negedge clk);
    #1;
    chk("mid_busy", busy_o, 1);
    chk("mid_mac_en", mac_en_o, 0);
    chk("mid_rd_en", rd_en_o, 0);
    chk("mid_rvalid", result_valid_o, 0);
    rst = 0;
    wait_clear();
    hist.delete();
    exp_head = 0;
    do_sample(16'($urandom), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
